pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 25 ++
 rtl/pc_sequencer_next.sv | 51 +++++
 rtl/pc_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [2:0] COND_NE = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_OV = 3'b110;
  localparam logic [2:0] COND_AL = 3'b111;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  localparam logic [15:0] RESET_PC = 16'h0000;

endpackage

// File: rtl/pc_sequencer_next.sv
// pc_next_calc: branch condition evaluation and next-PC arithmetic (pure combinational).
module pc_next_calc
  import pc_sequencer_pkg::*;
(
  input  logic [15:0] i_pc,
  input  logic [2:0]  i_flags,
  input  logic        i_branch_en,
  input  logic        i_branch_reg,
  input  logic [2:0]  i_cond,
  input  logic [8:0]  i_imm9,
  input  logic [15:0] i_reg_target,
  output logic [15:0] o_next_pc,
  output logic [15:0] o_pc_plus2
);

  logic        w_n, w_z, w_v, w_cond_ok;
  logic [15:0] w_offset;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    w_cond_ok = 1'b1;
    case (i_cond)
      COND_NE: w_cond_ok = !w_z;
      COND_EQ: w_cond_ok = w_z;
      COND_GT: w_cond_ok = !w_z && !w_n;
      COND_LT: w_cond_ok = w_n;
      COND_GE: w_cond_ok = w_z || (!w_z && !w_n);
      COND_LE: w_cond_ok = w_n || w_z;
      COND_OV: w_cond_ok = w_v;
      COND_AL: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b1;
    endcase
  end

  // Word offset: sign-extend and scale by 2 bytes.
  assign w_offset   = {{6{i_imm9[8]}}, i_imm9, 1'b0};
  assign o_pc_plus2 = i_pc + 16'd2;

  always_comb begin
    o_next_pc = o_pc_plus2;
    if (i_branch_reg) begin
      if (w_cond_ok) o_next_pc = i_reg_target;
    end else if (i_branch_en && w_cond_ok) begin
      o_next_pc = o_pc_plus2 + w_offset;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: FETCH (request word) -> EXEC (await retire) -> FETCH, or HALT (terminal until rst).
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        branch_en,
  input  logic        branch_reg,
  input  logic [2:0]  cond,
  input  logic [8:0]  imm9,
  input  logic [15:0] reg_target,
  input  logic        halt,
  input  logic [2:0]  flags_we,
  input  logic [2:0]  flags_in,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic [2:0]  flags,
  output logic        halted
);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt, w_next_pc;
  logic [2:0]  r_flags, w_flags_nxt;
  logic [15:0] r_instr;
  logic        r_instr_valid;
  logic        w_fetch_accept;

  pc_next_calc u_next (
    .i_pc         (r_pc),
    .i_flags      (r_flags),
    .i_branch_en  (branch_en),
    .i_branch_reg (branch_reg),
    .i_cond       (cond),
    .i_imm9       (imm9),
    .i_reg_target (reg_target),
    .o_next_pc    (w_next_pc),
    .o_pc_plus2   (pc_plus2)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_flags_nxt    = r_flags;
    w_fetch_accept = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (imem_ack) begin
          w_fetch_accept = 1'b1;
          w_state_nxt    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          if (halt) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_pc_nxt    = w_next_pc;
            w_flags_nxt = (r_flags & ~flags_we) | (flags_in & flags_we);
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_flags       <= 3'b000;
      r_instr       <= 16'h0000;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_flags       <= w_flags_nxt;
      r_instr_valid <= w_fetch_accept;
      if (w_fetch_accept) r_instr <= imem_data;
    end
  end

  // Gated by rst so the request is low for the whole reset and rises as soon as it releases.
  assign imem_req    = (r_state == ST_FETCH) && !rst;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign flags       = r_flags;
  assign halted      = (r_state == ST_HALT);

endmodule
